// File: rtl/alu_result_fifo_if.sv
// rtl/alu_result_fifo_if.sv - producer/consumer handshake bundle for the ALU result FIFO
interface alu_result_fifo_if #(
    parameter int DATA_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_y;
    logic              in_carry;
    logic [2:0]        in_sel;

    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_y;
    logic              out_carry;
    logic [2:0]        out_sel;
    logic              out_zero;

    // FIFO side
    modport slave (
        input  in_valid, in_y, in_carry, in_sel, out_ready,
        output in_ready, out_valid, out_y, out_carry, out_sel, out_zero
    );

    // Environment side: producer plus consumer
    modport master (
        output in_valid, in_y, in_carry, in_sel, out_ready,
        input  in_ready, out_valid, out_y, out_carry, out_sel, out_zero
    );
endinterface

// File: rtl/alu_result_fifo.sv
// rtl/alu_result_fifo.sv - first-word-fall-through FIFO for ALU results with zero tag and stall counter
module alu_result_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    alu_result_fifo_if.slave         bus,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic [CNT_W-1:0]         stall_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;
    localparam int ENT_W = DATA_W + 5;
    localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

    logic [ENT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_count;
    logic [CNT_W-1:0] r_stall;

    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;
    logic [ENT_W-1:0] w_wr_entry;

    // Flags come from the registered count only, so ready/valid never depend
    // combinationally on the opposite side of the handshake.
    assign w_full     = (r_count == FULL_CNT);
    assign w_empty    = (r_count == '0);
    assign w_push     = bus.in_valid && !w_full;
    assign w_pop      = bus.out_ready && !w_empty;
    assign w_wr_entry = {bus.in_sel, (bus.in_y == '0), bus.in_carry, bus.in_y};
    assign w_head     = r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_stall  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= w_wr_entry;
                r_wr_ptr        <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
            if (bus.in_valid && w_full && (r_stall != '1)) begin
                r_stall <= r_stall + 1'b1;
            end
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.out_valid = !w_empty;
    assign bus.out_y     = w_head[DATA_W-1:0];
    assign bus.out_carry = w_head[DATA_W];
    assign bus.out_zero  = w_head[DATA_W+1];
    assign bus.out_sel   = w_head[DATA_W+4:DATA_W+2];

    assign count     = r_count;
    assign full      = w_full;
    assign empty     = w_empty;
    assign stall_cnt = r_stall;
endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Buffers ALU results downstream of the 4-bit ALU (inputs y, carry, sel) and hands them to a consumer over a valid/ready interface.
- Tags each entry with the opcode that produced it and a computed zero flag.
- Absorbs back-pressure from the consumer and counts stalled producer cycles.

Parameters:
DATA_W, 4, width of the ALU result y
DEPTH, 4, number of FIFO entries; power of two, at least 2
CNT_W, 8, width of the saturating stall counter

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
clear  input  1  synchronous flush, priority over push/pop
in_valid  input  1  producer has a result
in_ready  output  1  FIFO accepts a result; equals !full
in_y  input  DATA_W  ALU result
in_carry  input  1  ALU carry/borrow
in_sel  input  3  ALU opcode that produced the result
out_valid  output  1  head entry valid; equals !empty
out_ready  input  1  consumer takes head entry
out_y  output  DATA_W  head result
out_carry  output  1  head carry
out_sel  output  3  head opcode
out_zero  output  1  head result equals 0
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
full  output  1  count == DEPTH
empty  output  1  count == 0
stall_cnt  output  CNT_W  cycles with in_valid && !in_ready, saturating

Behaviour:
- One clock domain. rst_n is asynchronous active-low: assertion clears the state immediately; deassertion is synchronous to clk.
- Reset values:
  - Pointers, count and stall_cnt = 0.
  - empty=1, full=0, in_ready=1, out_valid=0.
  - out_y/out_carry/out_sel/out_zero = 0, because storage resets to 0.
- Entry format: {sel[2:0], zero, carry, y[DATA_W-1:0]}.
  - zero = (in_y == 0), computed at write time.
  - carry is stored as given, including ops where the ALU forces it to 0.
- Push: fires when in_valid && in_ready. Writes mem[wr_ptr]; wr_ptr advances modulo DEPTH.
- Pop: fires when out_valid && out_ready. rd_ptr advances modulo DEPTH.
- Output timing:
  - First-word-fall-through: out_* is driven combinationally from mem[rd_ptr], with no read latency.
  - Write-to-out_valid latency is 1 cycle: an entry pushed at edge N is visible after edge N.
  - out_* is don't-care when out_valid=0, but must not be X after reset.
- Occupancy: count += push - pop each cycle.
  - Push and pop in the same cycle leaves count unchanged.
  - Legal only when 0 < count < DEPTH.
- Full: in_ready=0, so no push. A simultaneous pop does not enable a same-cycle push; there is no pass-through. After the pop, in_ready=1 next cycle.
- Empty: out_valid=0, so no pop. A push while empty does not bypass to the outputs in the same cycle.
- Stall counter: stall_cnt increments every cycle with in_valid && !in_ready. It saturates at 2^CNT_W-1 and does not wrap.
- Producer rule: in_* must stay stable while in_valid=1 and in_ready=0. The FIFO does not check this.
- clear=1 at a clock edge:
  - Pointers, count and stall_cnt go to 0.
  - Any push or pop in that cycle is discarded.
  - Storage contents need not be zeroed.
- Pointer wrap: ptr width is $clog2(DEPTH). full/empty derive from count, not from pointer comparison.
- rst_n asserted mid-transfer: all in-flight data is lost. Outputs go to reset values asynchronously.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Test Plan:
1. Reset, then push in_y=4'h9, carry=1, sel=3'b000. Next cycle: out_valid=1, out_y=9, out_carry=1, out_sel=0, out_zero=0, count=1.
2. Push y=0 with sel=3'b111, then y=4'hF with sel=3'b101, holding out_ready=0. Expect count=2, head out_zero=1, out_sel=7. Pop once: out_y=F, out_sel=5, out_zero=0.
3. With out_ready=0, push 4 entries (1,2,3,4). Expect full=1, in_ready=0. Hold in_valid=1 for 3 more cycles: stall_cnt=3 and entries unchanged. Drain: outputs 1,2,3,4 in order, then empty=1.
4. Stream 10 entries with in_valid=out_ready=1 continuously from count=1. Expect count stays 1, ordered output, and both pointers wrap past DEPTH-1.
5. With count=3, assert clear together with a push and a pop. Next cycle: count=0, empty=1, stall_cnt=0, out_valid=0.
6. With count=2, assert rst_n=0 mid-cycle. Expect immediate count=0, out_valid=0, in_ready=1. Release rst_n, then push 4'h5: appears as out_y=5 the next cycle. Separately, force 300 stall cycles with CNT_W=8: stall_cnt holds at 8'hFF.
